// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one SHA-256 compression core among NUM_REQ
// block-streaming requesters; the core stays locked to one owner per message.
module sha256_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [NUM_REQ*512-1:0] req_block,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [255:0]         rsp_digest,
  output logic                 core_init,
  output logic                 core_next,
  output logic [511:0]         core_block,
  input  logic                 core_ready,
  input  logic [255:0]         core_digest,
  input  logic                 core_digest_valid
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic                locked_q, locked_d;
  logic                first_q, first_d;
  logic                last_flag_q, last_flag_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [511:0]        core_block_q, core_block_d;
  logic [255:0]        rsp_digest_q, rsp_digest_d;

  logic [NUM_REQ-1:0]  owner_oh;
  logic [NUM_REQ-1:0]  cand;
  logic [NUM_REQ-1:0]  sel_oh;
  logic [ID_W-1:0]     sel_id;
  logic [ID_W-1:0]     pos;
  logic [511:0]        sel_block;
  logic                sel_last;

  // While locked only the owner is a candidate; otherwise scan from rr_ptr.
  always_comb begin : select
    owner_oh  = '0;
    sel_oh    = '0;
    sel_id    = '0;
    sel_block = '0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == ID_W'(i));
    end
    cand = locked_q ? (req_valid & owner_oh) : req_valid;
    pos  = rr_ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (sel_oh == '0 && cand[i] && pos == ID_W'(i)) begin
          sel_oh[i] = 1'b1;
          sel_id    = ID_W'(i);
          sel_block = req_block[i*512 +: 512];
          sel_last  = req_last[i];
        end
      end
      pos = (pos == ID_W'(NUM_REQ - 1)) ? '0 : pos + 1'b1;
    end
  end

  always_comb begin : fsm
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    rsp_id_d     = rsp_id_q;
    locked_d     = locked_q;
    first_d      = first_q;
    last_flag_d  = last_flag_q;
    rsp_valid_d  = rsp_valid_q;
    core_block_d = core_block_q;
    rsp_digest_d = rsp_digest_q;
    req_ready    = '0;
    core_init    = 1'b0;
    core_next    = 1'b0;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // reset_n gating keeps the combinational strobe low while in reset.
        if (reset_n && core_ready && !rsp_valid_q && sel_oh != '0) begin
          req_ready    = sel_oh;
          core_block_d = sel_block;
          last_flag_d  = sel_last;
          owner_d      = sel_id;
          first_d      = !locked_q;
          locked_d     = 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        core_init = first_q;
        core_next = !first_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (core_ready && core_digest_valid) begin
          if (last_flag_q) begin
            rsp_digest_d = core_digest;
            rsp_id_d     = owner_q;
            rsp_valid_d  = 1'b1;
            locked_d     = 1'b0;
            rr_ptr_d     = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      rsp_id_q     <= '0;
      locked_q     <= 1'b0;
      first_q      <= 1'b0;
      last_flag_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      core_block_q <= '0;
      rsp_digest_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      rsp_id_q     <= rsp_id_d;
      locked_q     <= locked_d;
      first_q      <= first_d;
      last_flag_q  <= last_flag_d;
      rsp_valid_q  <= rsp_valid_d;
      core_block_q <= core_block_d;
      rsp_digest_q <= rsp_digest_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_digest = rsp_digest_q;
  assign core_block = core_block_q;

endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: behavioural SHA-256 core model, requester queues,
// known-answer table, multi-cycle corner sequences and randomized round-robin traffic.
module tb_sha256_arbiter;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] N1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] N2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] NIST_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0, req_last = '0, req_ready;
  logic [NUM_REQ*512-1:0] req_block = '0;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [ID_W-1:0] rsp_id;
  logic [255:0] rsp_digest;
  logic core_init, core_next;
  logic [511:0] core_block;
  logic core_ready, core_digest_valid;
  logic [255:0] core_digest;

  always #5 clk = ~clk;

  sha256_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_last(req_last), .req_block(req_block), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_digest(rsp_digest),
    .core_init(core_init), .core_next(core_next), .core_block(core_block),
    .core_ready(core_ready), .core_digest(core_digest), .core_digest_valid(core_digest_valid));

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = w[t-16] + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3))
           + w[t-7] + (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10));
    for (int i = 0; i < 8; i++) hv[i] = h[255 - 32*i -: 32];
    a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; hh = hv[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d, hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + hh};
  endfunction

  // Core model: ready drops after init/next, digest appears 65 cycles later.
  logic [255:0] pend_h;
  int core_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready <= 1'b1; core_digest_valid <= 1'b0; core_digest <= '0;
      core_cnt <= 0; pend_h <= '0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0; core_digest_valid <= 1'b0; core_cnt <= 65;
      pend_h <= sha_compress(core_init ? IV : core_digest, core_block);
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1) begin
        core_ready <= 1'b1; core_digest_valid <= 1'b1; core_digest <= pend_h;
      end
    end
  end

  typedef struct {int id; logic [511:0] blk; logic last;} blk_t;
  typedef struct {int id; int cyc;} grant_t;
  typedef struct {int id; logic [255:0] dig; int cyc;} rsp_t;
  typedef struct {int id; int nblk; logic [511:0] b0; logic [511:0] b1; logic [255:0] dig;} vec_t;

  blk_t   pend[$];
  grant_t grant_log[$];
  rsp_t   rsp_log[$];
  int     init_log[$];
  int     next_log[$];
  int     cyc = 0;
  int     rsp_mode = 0;
  logic [NUM_REQ-1:0] acc;
  event   mon_ev;
  int     checks = 0, errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_blk(input int id, input logic [511:0] b, input logic last);
    pend.push_back('{id, b, last});
  endtask

  task automatic drive();
    req_valid = '0; req_last = '0; req_block = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < pend.size(); j++) begin
        if (pend[j].id == i) begin
          req_valid[i] = 1'b1; req_last[i] = pend[j].last; req_block[i*512 +: 512] = pend[j].blk;
          break;
        end
      end
    end
    case (rsp_mode)
      0: rsp_ready = 1'b1;
      1: rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Monitor samples on the falling edge; requesters update 1ns after the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      acc = '0;
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i]) begin acc[i] = 1'b1; grant_log.push_back('{i, cyc}); end
      if (core_init) init_log.push_back(cyc);
      if (core_next) next_log.push_back(cyc);
      if (rsp_valid && rsp_ready) rsp_log.push_back('{int'(rsp_id), rsp_digest, cyc});
      -> mon_ev;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          for (int j = 0; j < pend.size(); j++)
            if (pend[j].id == i) begin pend.delete(j); break; end
        end
      end
      drive();
    end
  end

  task automatic tick();
    @(mon_ev);
  endtask

  task automatic do_reset();
    tick();
    reset_n = 1'b0;
    pend.delete();
    rsp_mode = 0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_rsp(input int n_total, input int budget, input string nm);
    int t;
    t = 0;
    while (rsp_log.size() < n_total && t < budget) begin tick(); t++; end
    chk(nm, rsp_log.size(), n_total);
  endtask

  vec_t tbl [4];
  int r0, g0, i0, n0, gsz, viol, nexp, ptr, total;
  int nmsg [NUM_REQ];
  int taken [NUM_REQ];
  logic [255:0] mdig [NUM_REQ][4];
  rsp_t exp_q[$];
  logic [255:0] cap_d, h;
  logic [ID_W-1:0] cap_id;
  logic [511:0] rb;

  initial begin
    tbl[0] = '{0, 1, ABC, '0, ABC_DIG};
    tbl[1] = '{1, 2, N1, N2, NIST_DIG};
    tbl[2] = '{1, 1, ABC, '0, ABC_DIG};
    tbl[3] = '{0, 2, N1, N2, NIST_DIG};

    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_digest, core_init, core_next}, '0);
    chk("reset_core_block", core_block, '0);
    reset_n = 1'b1;
    tick();

    // Known-answer table
    for (int v = 0; v < 4; v++) begin
      r0 = rsp_log.size(); g0 = grant_log.size(); i0 = init_log.size(); n0 = next_log.size();
      push_blk(tbl[v].id, tbl[v].b0, tbl[v].nblk == 1);
      if (tbl[v].nblk == 2) push_blk(tbl[v].id, tbl[v].b1, 1'b1);
      wait_rsp(r0 + 1, 400, "tbl_rsp_count");
      if (rsp_log.size() > r0) begin
        chk("tbl_rsp_id", rsp_log[r0].id, tbl[v].id);
        chk("tbl_digest", rsp_log[r0].dig, tbl[v].dig);
        chk("tbl_latency", rsp_log[r0].cyc - grant_log[g0].cyc, 68 * tbl[v].nblk);
      end
      chk("tbl_init_count", init_log.size() - i0, 1);
      chk("tbl_next_count", next_log.size() - n0, tbl[v].nblk - 1);
      repeat (2) tick();
    end

    // Simultaneous requests: round-robin 0, 1, then 0 again
    do_reset();
    r0 = rsp_log.size(); g0 = grant_log.size();
    push_blk(0, ABC, 1'b1);
    push_blk(1, ABC, 1'b1);
    wait_rsp(r0 + 1, 400, "rr_first_rsp");
    push_blk(0, ABC, 1'b1);
    wait_rsp(r0 + 3, 600, "rr_rsp_count");
    if (rsp_log.size() >= r0 + 3) begin
      chk("rr_ids", {rsp_log[r0].id[1:0], rsp_log[r0+1].id[1:0], rsp_log[r0+2].id[1:0]}, 6'b00_01_00);
      chk("rr_grant_ids", {grant_log[g0].id[1:0], grant_log[g0+1].id[1:0], grant_log[g0+2].id[1:0]}, 6'b00_01_00);
    end

    // Locked owner: req1 waits for req0's two-block message
    do_reset();
    r0 = rsp_log.size(); g0 = grant_log.size(); n0 = next_log.size();
    push_blk(0, N1, 1'b0);
    push_blk(0, N2, 1'b1);
    push_blk(1, ABC, 1'b1);
    wait_rsp(r0 + 2, 600, "lock_rsp_count");
    chk("lock_grant_count", grant_log.size(), g0 + 3);
    if (grant_log.size() >= g0 + 3 && rsp_log.size() >= r0 + 2 && next_log.size() > n0) begin
      chk("lock_grant_ids", {grant_log[g0].id[1:0], grant_log[g0+1].id[1:0], grant_log[g0+2].id[1:0]}, 6'b00_00_01);
      chk("lock_block_spacing", grant_log[g0+1].cyc - grant_log[g0].cyc, 68);
      chk("lock_next_before_req1", next_log[n0] < grant_log[g0+2].cyc, 1);
      chk("lock_req1_after_rsp", grant_log[g0+2].cyc - rsp_log[r0].cyc, 1);
      chk("lock_digest0", rsp_log[r0].dig, NIST_DIG);
      chk("lock_digest1", {rsp_log[r0+1].id[1:0], rsp_log[r0+1].dig}, {2'd1, ABC_DIG});
    end

    // Back-pressure: rsp_ready low for 100 cycles
    do_reset();
    r0 = rsp_log.size();
    rsp_mode = 1;
    push_blk(0, ABC, 1'b1);
    push_blk(1, ABC, 1'b1);
    viol = 0;
    while (!rsp_valid && viol < 400) begin tick(); viol++; end
    chk("bp_rsp_valid_seen", rsp_valid, 1'b1);
    cap_d = rsp_digest; cap_id = rsp_id; gsz = grant_log.size(); viol = 0;
    repeat (100) begin
      tick();
      if (!rsp_valid || rsp_digest !== cap_d || rsp_id !== cap_id || req_ready != '0) viol++;
    end
    chk("bp_hold_violations", viol, 0);
    chk("bp_no_grant", grant_log.size(), gsz);
    chk("bp_held_rsp", {cap_id, cap_d}, {1'b0, ABC_DIG});
    rsp_mode = 0;
    wait_rsp(r0 + 1, 20, "bp_accept");
    viol = 0;
    while (grant_log.size() <= gsz && viol < 20) begin tick(); viol++; end
    chk("bp_grant_after_accept", grant_log.size(), gsz + 1);
    if (grant_log.size() > gsz && rsp_log.size() > r0)
      chk("bp_resume_delay", grant_log[gsz].cyc - rsp_log[r0].cyc, 1);
    wait_rsp(r0 + 2, 400, "bp_second_rsp");
    if (rsp_log.size() >= r0 + 2) chk("bp_second", {rsp_log[r0+1].id[1:0], rsp_log[r0+1].dig}, {2'd1, ABC_DIG});

    // Reset during WAIT aborts the message
    do_reset();
    g0 = grant_log.size();
    push_blk(1, N1, 1'b0);
    push_blk(1, N2, 1'b1);
    viol = 0;
    while (grant_log.size() <= g0 && viol < 50) begin tick(); viol++; end
    repeat (20) tick();
    reset_n = 1'b0;
    #1;
    chk("abort_outputs_zero", {req_ready, rsp_valid, rsp_id, rsp_digest, core_init, core_next}, '0);
    chk("abort_core_block", core_block, '0);
    pend.delete();
    r0 = rsp_log.size();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (150) tick();
    chk("abort_no_rsp", rsp_log.size(), r0);
    i0 = init_log.size();
    push_blk(0, ABC, 1'b1);
    wait_rsp(r0 + 1, 400, "abort_fresh_rsp");
    if (rsp_log.size() > r0) chk("abort_fresh", {rsp_log[r0].id[1:0], rsp_log[r0].dig}, {2'd0, ABC_DIG});
    chk("abort_fresh_init", init_log.size() - i0, 1);

    // Randomized traffic against a round-robin message-order model
    for (int round = 0; round < 3; round++) begin
      do_reset();
      rsp_mode = 2;
      r0 = rsp_log.size();
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        nmsg[i] = $urandom_range(1, 3);
        taken[i] = 0;
        total += nmsg[i];
        for (int m = 0; m < nmsg[i]; m++) begin
          int len;
          len = $urandom_range(1, 3);
          h = IV;
          for (int b = 0; b < len; b++) begin
            for (int w = 0; w < 16; w++) rb[w*32 +: 32] = $urandom();
            h = sha_compress(h, rb);
            push_blk(i, rb, b == len - 1);
          end
          mdig[i][m] = h;
        end
      end
      exp_q.delete();
      ptr = 0;
      nexp = total;
      while (total > 0) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int i;
          i = (ptr + k) % NUM_REQ;
          if (taken[i] < nmsg[i]) begin
            exp_q.push_back('{i, mdig[i][taken[i]], 0});
            taken[i]++;
            total--;
            ptr = (i + 1) % NUM_REQ;
            break;
          end
        end
      end
      wait_rsp(r0 + nexp, 3000, "rnd_rsp_count");
      for (int k = 0; k < nexp; k++) begin
        if (rsp_log.size() > r0 + k) begin
          chk("rnd_rsp_id", rsp_log[r0+k].id, exp_q[k].id);
          chk("rnd_digest", rsp_log[r0+k].dig, exp_q[k].dig);
        end
      end
      rsp_mode = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
